// File: rtl/fifo_gen2_pkg.sv
// Shared definitions for the second-generation block-RAM FIFO.
// Contents: read-mode constants and a constant-evaluable clog2 helper.
package fifo_gen2_pkg;

   localparam int unsigned FIFO_MODE_STD  = 0;
   localparam int unsigned FIFO_MODE_FWFT = 1;

   // Ceiling log2; usable in parameter defaults.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      int unsigned v;
      result = 0;
      v      = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Ports:
//   clk, rst_n          clock, async active-low reset (read register only)
//   wr_en/addr/data     write port
//   rd_en/addr          read request; rd_data valid the cycle after rd_en
//   rd_data             registered read data, holds between reads
module fifo_sdp_ram #(
   parameter int unsigned Width     = 9,
   parameter int unsigned Depth     = 8192,
   parameter int unsigned AddrWidth = 13
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [AddrWidth-1:0] wr_addr,
   input  logic [Width-1:0]     wr_data,
   input  logic                 rd_en,
   input  logic [AddrWidth-1:0] rd_addr,
   output logic [Width-1:0]     rd_data
);

   logic [Width-1:0] mem [Depth];

   // Storage array carries no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read register; reset only so the FIFO output starts at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/block_ram_fifo_gen2.sv
// Synchronous block-RAM FIFO with standard or first-word-fall-through read,
// programmable full/empty thresholds, synchronous flush and sticky error flags.
// Optional feature macro: FIFO_HIGH_WATER_EN enables the PeakCount high-water
// mark; when undefined PeakCount is tied to zero.
// Ports:
//   Clk, Reset_n        clock, async active-low reset
//   Flush               synchronous empty, overrides Write/Read
//   Write, Din          push request and data
//   Read                std: request a word; FWFT: consume Dout
//   Dout, Valid, Empty  read data, data-valid, nothing readable
//   Full                DataCount == Depth
//   ProgFullThresh      ProgFull when DataCount >= thresh
//   ProgEmptyThresh     ProgEmpty when DataCount <= thresh
//   DataCount           words held including the FWFT pipeline
//   Overflow/Underflow  sticky rejected write / read
//   ClearStatus         clears sticky flags and PeakCount
//   PeakCount           high-water mark of DataCount
module block_ram_fifo_gen2
   import fifo_gen2_pkg::*;
#(
   parameter int unsigned Width         = 9,
   parameter int unsigned Depth         = 8192,
   parameter int unsigned FirstWordFall = FIFO_MODE_STD,
   parameter int unsigned CountWidth    = clog2(Depth) + 1
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  Flush,
   input  logic                  Write,
   input  logic [Width-1:0]      Din,
   input  logic                  Read,
   output logic [Width-1:0]      Dout,
   output logic                  Valid,
   output logic                  Empty,
   output logic                  Full,
   input  logic [CountWidth-1:0] ProgFullThresh,
   input  logic [CountWidth-1:0] ProgEmptyThresh,
   output logic                  ProgFull,
   output logic                  ProgEmpty,
   output logic [CountWidth-1:0] DataCount,
   output logic                  Overflow,
   output logic                  Underflow,
   input  logic                  ClearStatus,
   output logic [CountWidth-1:0] PeakCount
);

   localparam int unsigned AddrWidth = CountWidth - 1;

   logic [AddrWidth-1:0]  wr_ptr;
   logic [AddrWidth-1:0]  rd_ptr;
   logic [CountWidth-1:0] count_nxt;
   logic [Width-1:0]      ram_q;
   logic                  wr_acc;
   logic                  rd_acc;
   logic                  ovf_evt;
   logic                  udf_evt;
   logic                  ram_rd;
   logic                  valid_nxt;
   logic                  empty_nxt;

   // Accept/reject decisions use pre-edge Full/Empty; Flush suppresses both.
   always_comb begin
      wr_acc    = Write && !Full && !Flush;
      rd_acc    = Read && !Empty && !Flush;
      ovf_evt   = Write && Full && !Flush;
      udf_evt   = Read && Empty && !Flush;
      count_nxt = DataCount;
      if (Flush) begin
         count_nxt = '0;
      end else if (wr_acc && !rd_acc) begin
         count_nxt = DataCount + CountWidth'(1);
      end else if (!wr_acc && rd_acc) begin
         count_nxt = DataCount - CountWidth'(1);
      end
   end

   fifo_sdp_ram #(
      .Width     (Width),
      .Depth     (Depth),
      .AddrWidth (AddrWidth)
   ) u_ram (
      .clk     (Clk),
      .rst_n   (Reset_n),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr),
      .wr_data (Din),
      .rd_en   (ram_rd),
      .rd_addr (rd_ptr),
      .rd_data (ram_q)
   );

   generate
      if (FirstWordFall == FIFO_MODE_FWFT) begin : g_fwft
         // Two-stage prefetch: RAM read register (q_vld) feeds the output
         // register, so a popped word is replaced every cycle.
         logic                  q_vld;
         logic                  q_vld_nxt;
         logic                  move;
         logic [CountWidth-1:0] ram_cnt;
         logic [CountWidth-1:0] ram_cnt_nxt;
         logic [Width-1:0]      dout_q;

         always_comb begin
            move        = q_vld && (!Valid || rd_acc) && !Flush;
            ram_rd      = (ram_cnt != '0) && (!q_vld || move) && !Flush;
            valid_nxt   = Valid;
            q_vld_nxt   = q_vld;
            ram_cnt_nxt = ram_cnt;
            if (Flush) begin
               valid_nxt = 1'b0;
            end else if (move) begin
               valid_nxt = 1'b1;
            end else if (rd_acc) begin
               valid_nxt = 1'b0;
            end
            if (Flush) begin
               q_vld_nxt = 1'b0;
            end else if (ram_rd) begin
               q_vld_nxt = 1'b1;
            end else if (move) begin
               q_vld_nxt = 1'b0;
            end
            if (Flush) begin
               ram_cnt_nxt = '0;
            end else if (wr_acc && !ram_rd) begin
               ram_cnt_nxt = ram_cnt + CountWidth'(1);
            end else if (!wr_acc && ram_rd) begin
               ram_cnt_nxt = ram_cnt - CountWidth'(1);
            end
            empty_nxt = !valid_nxt;
         end

         always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
               q_vld   <= 1'b0;
               ram_cnt <= '0;
               dout_q  <= '0;
            end else begin
               q_vld   <= q_vld_nxt;
               ram_cnt <= ram_cnt_nxt;
               if (move) begin
                  dout_q <= ram_q;
               end
            end
         end

         assign Dout = dout_q;
      end else begin : g_std
         // Standard read: RAM read register is the output, Valid pulses once per word.
         always_comb begin
            ram_rd    = rd_acc;
            valid_nxt = rd_acc;
            empty_nxt = (count_nxt == '0);
         end

         assign Dout = ram_q;
      end
   endgenerate

   // Pointers, occupancy and status flags.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         DataCount <= '0;
         Valid     <= 1'b0;
         Empty     <= 1'b1;
         Full      <= 1'b0;
         ProgFull  <= 1'b0;
         ProgEmpty <= 1'b1;
         Overflow  <= 1'b0;
         Underflow <= 1'b0;
      end else begin
         if (Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_acc) begin
               wr_ptr <= wr_ptr + AddrWidth'(1);
            end
            if (ram_rd) begin
               rd_ptr <= rd_ptr + AddrWidth'(1);
            end
         end
         DataCount <= count_nxt;
         Valid     <= valid_nxt;
         Empty     <= empty_nxt;
         Full      <= (count_nxt == CountWidth'(Depth));
         ProgFull  <= (count_nxt >= ProgFullThresh);
         ProgEmpty <= (count_nxt <= ProgEmptyThresh);
         // A new error in the same cycle as ClearStatus keeps the flag set.
         Overflow  <= (Overflow && !ClearStatus) || ovf_evt;
         Underflow <= (Underflow && !ClearStatus) || udf_evt;
      end
   end

`ifdef FIFO_HIGH_WATER_EN
   // High-water mark of occupancy since reset or ClearStatus.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         PeakCount <= '0;
      end else if (ClearStatus) begin
         PeakCount <= '0;
      end else if (count_nxt > PeakCount) begin
         PeakCount <= count_nxt;
      end
   end
`else
   assign PeakCount = '0;
`endif

endmodule
